// File: rtl/interrupt_ctrl_if.sv
// Sequencer-side bundle for the interrupt controller.
// Instruction and accumulator keep the PDP-8 [0:11] bit numbering.
interface interrupt_ctrl_if;
  logic [4:0]  state;
  logic [0:11] instruction;
  logic [0:11] ac;
  logic        int_in_prog;
  logic [7:0]  dev_req;
  logic        int_ena;
  logic        int_inh;
  logic        int_req;
  logic        skip;
  logic        ie_bit;

  modport master (
    output state, instruction, ac,
    output int_in_prog, dev_req,
    input  int_ena, int_inh, int_req,
    input  skip, ie_bit
  );

  modport slave (
    input  state, instruction, ac,
    input  int_in_prog, dev_req,
    output int_ena, int_inh, int_req,
    output skip, ie_bit
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// PDP-8 style interrupt enable/inhibit/request control.
// Local IOTs act once per F3; ION/RTF enables land at the next F1.
module interrupt_ctrl (
  input  logic            clk,
  input  logic            reset,
  interrupt_ctrl_if.slave bus
);

  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] E0 = 5'd4;

  logic       ion_pend;
  logic       done;
  logic       f3;
  logic       loc;
  logic [2:0] op;
  logic       ion, iof, skon;
  logic       srq, rtf, caf;
  logic       cif, jmp, grant;

  assign op  = bus.instruction[9:11];
  assign f3  = (bus.state == F3) && !done;
  assign loc = bus.instruction[0:8] == 9'o600;

  always_comb begin
    ion  = 1'b0;
    iof  = 1'b0;
    skon = 1'b0;
    srq  = 1'b0;
    rtf  = 1'b0;
    caf  = 1'b0;
    if (f3 && loc) begin
      unique case (op)
        3'o0:    skon = 1'b1;
        3'o1:    ion  = 1'b1;
        3'o2:    iof  = 1'b1;
        3'o3:    srq  = 1'b1;
        3'o5:    rtf  = 1'b1;
        3'o7:    caf  = 1'b1;
        default: ;
      endcase
    end
  end

  // CIF/CDI family: 62x2, 62x3, 62x4
  assign cif = f3
    && (bus.instruction[0:5] == 6'o62)
    && (op inside {3'o2, 3'o3, 3'o4});

  assign jmp = (bus.state == F1)
    && (bus.instruction[0:1] == 2'b10);

  assign grant = (bus.state == E0)
    && bus.int_in_prog;

  assign bus.skip = !reset
    && ((skon && bus.int_ena)
     || (srq && bus.int_req));

  assign bus.ie_bit = bus.int_ena;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.int_ena <= 1'b0;
      bus.int_inh <= 1'b0;
      bus.int_req <= 1'b0;
      ion_pend    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= bus.state == F3;
      bus.int_req <= |bus.dev_req;
      if (grant) begin
        bus.int_ena <= 1'b0;
        ion_pend    <= 1'b0;
      end else if (iof || skon || caf) begin
        bus.int_ena <= 1'b0;
        ion_pend    <= 1'b0;
      end else if (ion || (rtf && bus.ac[2])) begin
        ion_pend    <= 1'b1;
      end else if (bus.state == F1 && ion_pend) begin
        bus.int_ena <= 1'b1;
        ion_pend    <= 1'b0;
      end
      if (caf)
        bus.int_inh <= 1'b0;
      else if (cif)
        bus.int_inh <= 1'b1;
      else if (jmp)
        bus.int_inh <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl with a queue-based scoreboard.
// Stimulus pushes expected outputs; the monitor pops one per cycle.
module tb_interrupt_ctrl;

  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] E0 = 5'd4;

  localparam logic [11:0] SKON = 12'o6000;
  localparam logic [11:0] ION  = 12'o6001;
  localparam logic [11:0] IOF  = 12'o6002;
  localparam logic [11:0] SRQ  = 12'o6003;
  localparam logic [11:0] RTF  = 12'o6005;
  localparam logic [11:0] CAF  = 12'o6007;
  localparam logic [11:0] CIF  = 12'o6212;
  localparam logic [11:0] CLA  = 12'o7200;
  localparam logic [11:0] NOP  = 12'o7000;
  localparam logic [11:0] TAD  = 12'o1234;
  localparam logic [11:0] JMP  = 12'o5200;

  typedef struct {
    string nm;
    logic  ena;
    logic  inh;
    logic  req;
    logic  sk;
  } exp_t;

  logic clk;
  logic reset;
  logic vld;
  exp_t q[$];
  int   tests;
  int   fails;

  logic [11:0] g_ac;
  logic [7:0]  g_dev;
  logic        g_ip;
  logic        g_rst;
  logic        c_ena;
  logic        c_inh;

  interrupt_ctrl_if bus ();

  interrupt_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic [4:0]  st,
    input logic [11:0] ins,
    input logic        ea,
    input logic        ei,
    input logic        sk,
    input string       nm
  );
    exp_t e;
    @(posedge clk);
    #2;
    bus.state       = st;
    bus.instruction = ins;
    bus.ac          = g_ac;
    bus.dev_req     = g_dev;
    bus.int_in_prog = g_ip;
    reset           = g_rst;
    vld             = 1'b1;
    e.nm  = nm;
    e.ena = ea;
    e.inh = ei;
    e.req = g_rst ? 1'b0 : |g_dev;
    e.sk  = sk;
    q.push_back(e);
  endtask

  // One F0..F3 fetch; a1/i1 hold after F1, a3/i3 after F3.
  task automatic fetch(
    input logic [11:0] ins,
    input logic        a1,
    input logic        i1,
    input logic        a3,
    input logic        i3,
    input logic        sk,
    input string       nm
  );
    step(F0, ins, c_ena, c_inh, 1'b0, {nm, "_f0"});
    c_ena = a1;
    c_inh = i1;
    step(F1, ins, c_ena, c_inh, 1'b0, {nm, "_f1"});
    step(F2, ins, c_ena, c_inh, 1'b0, {nm, "_f2"});
    c_ena = a3;
    c_inh = i3;
    step(F3, ins, c_ena, c_inh, sk, {nm, "_f3"});
  endtask

  initial begin : monitor
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      if (vld) begin
        s = bus.skip;
        @(posedge clk);
        #1;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL underflow: no expected entry");
        end else begin
          e = q.pop_front();
          if (bus.int_ena !== e.ena
           || bus.ie_bit  !== e.ena
           || bus.int_inh !== e.inh
           || bus.int_req !== e.req
           || s           !== e.sk) begin
            fails++;
            $display(
              "FAIL %s: got ena=%b ie=%b inh=%b req=%b skip=%b exp ena=%b inh=%b req=%b skip=%b",
              e.nm, bus.int_ena, bus.ie_bit,
              bus.int_inh, bus.int_req, s,
              e.ena, e.inh, e.req, e.sk);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : stim
    tests = 0;
    fails = 0;
    vld   = 1'b0;
    reset = 1'b1;
    bus.state       = F0;
    bus.instruction = NOP;
    bus.ac          = '0;
    bus.dev_req     = '0;
    bus.int_in_prog = 1'b0;
    g_ac  = '0;
    g_dev = 8'h01;
    g_ip  = 1'b0;
    g_rst = 1'b1;
    c_ena = 1'b0;
    c_inh = 1'b0;

    step(F0, NOP, 1'b0, 1'b0, 1'b0, "reset");
    g_rst = 1'b0;

    // ION then CLA: enable appears at F1 of CLA
    fetch(ION, 0, 0, 0, 0, 0, "ion");
    fetch(CLA, 1, 0, 1, 0, 0, "cla");
    step(F0, NOP, 1'b1, 1'b0, 1'b0, "f0_after");
    g_ip = 1'b1;
    step(E0, NOP, 1'b0, 1'b0, 1'b0, "grant");
    g_ip  = 1'b0;
    c_ena = 1'b0;

    // ION then IOF before the next F1
    fetch(ION, 0, 0, 0, 0, 0, "ion_b");
    step(F2, IOF, 1'b0, 1'b0, 1'b0, "iof_f2");
    step(F3, IOF, 1'b0, 1'b0, 1'b0, "iof_f3");
    fetch(NOP, 0, 0, 0, 0, 0, "no_en");

    // SKON with and without enable, SRQ with and without request
    fetch(ION,  0, 0, 0, 0, 0, "ion_c");
    fetch(NOP,  1, 0, 1, 0, 0, "en_c");
    fetch(SKON, 1, 0, 0, 0, 1, "skon1");
    fetch(SKON, 0, 0, 0, 0, 0, "skon0");
    fetch(SRQ,  0, 0, 0, 0, 1, "srq1");
    step(F3, SRQ, 1'b0, 1'b0, 1'b0, "srq_hold");
    g_dev = 8'h00;
    fetch(SRQ,  0, 0, 0, 0, 0, "srq0");
    g_dev = 8'h80;

    // CIF, TAD, JMP: inhibit held until JMP F1
    fetch(CIF, 0, 0, 0, 1, 0, "cif");
    fetch(TAD, 0, 1, 0, 1, 0, "tad");
    step(E0, TAD, 1'b0, 1'b1, 1'b0, "tad_e0");
    fetch(JMP, 0, 0, 0, 0, 0, "jmp");

    // Grant in E0 with ION on the bus clears a pending enable
    fetch(ION, 0, 0, 0, 0, 0, "ion_e");
    fetch(NOP, 1, 0, 1, 0, 0, "en_e");
    fetch(ION, 1, 0, 1, 0, 0, "ion_e2");
    g_ip = 1'b1;
    step(E0, ION, 1'b0, 1'b0, 1'b0, "grant_ion");
    g_ip  = 1'b0;
    c_ena = 1'b0;
    fetch(NOP, 0, 0, 0, 0, 0, "no_pend");

    // CAF clears enable and inhibit; request keeps following
    fetch(CIF, 0, 0, 0, 1, 0, "cif_f");
    fetch(ION, 0, 1, 0, 1, 0, "ion_f");
    fetch(NOP, 1, 1, 1, 1, 0, "en_f");
    fetch(CAF, 1, 1, 0, 0, 0, "caf");
    fetch(NOP, 0, 0, 0, 0, 0, "after_caf");

    // RTF with ac[2] set / clear, and reset discarding the pend
    g_ac = 12'o1000;
    fetch(RTF, 0, 0, 0, 0, 0, "rtf1");
    fetch(NOP, 1, 0, 1, 0, 0, "rtf_en");
    fetch(IOF, 1, 0, 0, 0, 0, "iof_g");
    g_ac = 12'o0000;
    fetch(RTF, 0, 0, 0, 0, 0, "rtf0");
    fetch(NOP, 0, 0, 0, 0, 0, "rtf0_no");
    g_ac = 12'o1000;
    fetch(CIF, 0, 0, 0, 1, 0, "cif_r");
    fetch(RTF, 0, 1, 0, 1, 0, "rtf_r");
    g_rst = 1'b1;
    step(F0, NOP, 1'b0, 1'b0, 1'b0, "rst_pend");
    g_rst = 1'b0;
    c_ena = 1'b0;
    c_inh = 1'b0;
    fetch(NOP, 0, 0, 0, 0, 0, "rst_no_en");

    @(posedge clk);
    #2;
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d entries, exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
